// File: rtl/urv_dm_bridge_pkg.sv
// Shared types and constants for the uRV data-memory to Wishbone bridge.
package urv_dm_bridge_pkg;

    localparam int TMO_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } bridge_state_e;

    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/urv_dm_timeout.sv
// Wait-for-ack watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the g_limit-th enabled cycle is reached (g_limit=0 disables).
module urv_dm_timeout
    import urv_dm_bridge_pkg::*;
#(
    parameter int unsigned g_limit = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(g_limit - 1);

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (g_limit != 0) && enable && (cnt_q == LAST);

endmodule

// File: rtl/urv_dm_wb_bridge.sv
// Bridges the uRV data-memory load/store pulses onto a pipelined Wishbone
// master, one access in flight, with error/timeout reporting.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no access; a load/store pulse latches the request
//   ST_REQ  | cyc+stb asserted, held while the slave stalls
//   ST_WAIT | stb accepted, cyc held, waiting for ack/err or timeout
//   ST_DONE | cyc dropped, one done pulse (plus bus_err_o on failure)
module urv_dm_wb_bridge
    import urv_dm_bridge_pkg::*;
#(
    parameter int unsigned g_timeout  = 255,
    parameter logic [31:0] g_err_data = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i,
    output logic        bus_err_o,
    output logic [31:0] err_addr_o,
    output logic        proto_err_o
);

    bridge_state_e state_q, state_d;
    logic [31:0]   addr_q, data_q;
    logic [3:0]    sel_q;
    logic          we_q, err_q;
    logic          req_any, bus_resp, finish, fail, tmo_expired;

    assign req_any  = dm_load_i | dm_store_i;
    assign bus_resp = wb_ack_i | wb_err_i;

    urv_dm_timeout #(
        .g_limit (g_timeout)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear   (state_q != ST_WAIT),
        .enable  (state_q == ST_WAIT),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        finish  = 1'b0;
        fail    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_any) state_d = ST_IDLE == ST_IDLE ? ST_REQ : ST_IDLE;
            end
            ST_REQ: begin
                // A response is only meaningful once the strobe has been accepted.
                if (!wb_stall_i) begin
                    if (bus_resp) begin
                        state_d = ST_DONE;
                        finish  = 1'b1;
                        fail    = wb_err_i;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus_resp) begin
                    state_d = ST_DONE;
                    finish  = 1'b1;
                    fail    = wb_err_i;
                end else if (tmo_expired) begin
                    state_d = ST_DONE;
                    finish  = 1'b1;
                    fail    = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            dm_data_l_o <= '0;
            err_addr_o  <= '0;
            proto_err_o <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= fail;
            if (state_q == ST_IDLE && req_any) begin
                addr_q <= dm_addr_i;
                data_q <= dm_data_s_i;
                sel_q  <= dm_data_select_i;
                we_q   <= dm_store_i;
            end
            if (finish && !we_q) begin
                dm_data_l_o <= fail ? g_err_data : wb_dat_i;
            end
            if (fail) begin
                err_addr_o <= addr_q;
            end
            // A store wins over a simultaneous load, but the overlap is still a CPU bug.
            if ((req_any && state_q != ST_IDLE) || (dm_load_i && dm_store_i)) begin
                proto_err_o <= 1'b1;
            end
        end
    end

    assign wb_cyc_o        = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign wb_stb_o        = (state_q == ST_REQ);
    assign wb_we_o         = we_q;
    assign wb_adr_o        = word_addr(addr_q);
    assign wb_sel_o        = sel_q;
    assign wb_dat_o        = data_q;
    assign dm_load_done_o  = (state_q == ST_DONE) && !we_q;
    assign dm_store_done_o = (state_q == ST_DONE) && we_q;
    assign bus_err_o       = err_q;

endmodule
